// File: rtl/paddle_timer_ctrl.sv
// Paddle pot + one-shot replacement: latches a slew-limited paddle position once
// per frame and emits a PAD_OUT pulse lasting OFFSET + (POS_CUR >> SHIFT) scanlines.
module paddle_timer_ctrl #(
  parameter int POS_W       = 8,
  parameter int SHIFT       = 1,
  parameter int OFFSET      = 8,
  parameter int MAX_STEP    = 16,
  parameter int ATTRACT_POS = 128
) (
  input  logic             CLK_DRV,
  input  logic             RESET,
  input  logic             VSYNC_N,
  input  logic             HSYNC_N,
  input  logic             PAD_EN_N,
  input  logic [POS_W-1:0] POS1,
  input  logic [POS_W-1:0] POS2,
  input  logic             PLAYER2,
  input  logic             ATTRACT_N,
  output logic             PAD_OUT,
  output logic             PAD_SEL,
  output logic [POS_W-1:0] POS_CUR
);

  localparam logic [POS_W-1:0] STEP_V    = POS_W'(MAX_STEP);
  localparam logic [POS_W-1:0] ATTRACT_V = POS_W'(ATTRACT_POS);
  localparam logic [POS_W:0]   OFFSET_V  = (POS_W+1)'(OFFSET);

  typedef enum logic [1:0] {IDLE, ARMED, TIMING, DONE} state_t;

  state_t           state, state_n;
  logic [POS_W:0]   count, count_n, count_inc, pulse_len;
  logic [POS_W-1:0] pos1_p0, pos1_p1, pos2_p0, pos2_p1, target;
  logic             player2_p0, player2_p1, attract_p0, attract_p1;
  logic             vsync_p0, vsync_p1, hsync_p0, hsync_p1, pad_en_p0, pad_en_p1;
  logic             frame_latch, hs_fall, pe_fall;

  function automatic logic [POS_W-1:0] slew_step(input logic [POS_W-1:0] cur,
                                                 input logic [POS_W-1:0] tgt);
    logic [POS_W-1:0] diff;
    if (tgt > cur) begin
      diff      = tgt - cur;
      slew_step = (diff > STEP_V) ? cur + STEP_V : tgt;
    end else begin
      diff      = cur - tgt;
      slew_step = (diff > STEP_V) ? cur - STEP_V : tgt;
    end
  endfunction

  // Stage p0/p1: position buses are treated as data and carry no reset
  always_ff @(posedge CLK_DRV) begin
    pos1_p0 <= POS1;
    pos1_p1 <= pos1_p0;
    pos2_p0 <= POS2;
    pos2_p1 <= pos2_p0;
  end

  // Stage p0/p1: control synchronisers; sync copies reset high so release makes no edge
  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) begin
      player2_p0 <= 1'b0;
      player2_p1 <= 1'b0;
      attract_p0 <= 1'b0;
      attract_p1 <= 1'b0;
      vsync_p0   <= 1'b1;
      vsync_p1   <= 1'b1;
      hsync_p0   <= 1'b1;
      hsync_p1   <= 1'b1;
      pad_en_p0  <= 1'b1;
      pad_en_p1  <= 1'b1;
    end else begin
      player2_p0 <= PLAYER2;
      player2_p1 <= player2_p0;
      attract_p0 <= ATTRACT_N;
      attract_p1 <= attract_p0;
      vsync_p0   <= VSYNC_N;
      vsync_p1   <= vsync_p0;
      hsync_p0   <= HSYNC_N;
      hsync_p1   <= hsync_p0;
      pad_en_p0  <= PAD_EN_N;
      pad_en_p1  <= pad_en_p0;
    end
  end

  assign frame_latch = vsync_p1 & ~vsync_p0;
  assign hs_fall     = hsync_p1 & ~hsync_p0;
  assign pe_fall     = pad_en_p1 & ~pad_en_p0;
  assign target      = attract_p1 ? (player2_p1 ? pos2_p1 : pos1_p1) : ATTRACT_V;
  assign pulse_len   = OFFSET_V + {1'b0, POS_CUR >> SHIFT};
  assign count_inc   = count + 1'b1;

  always_comb begin
    state_n = state;
    count_n = count;
    if (frame_latch) begin
      // Frame latch wins over a simultaneous trigger and truncates a running pulse
      state_n = ARMED;
    end else begin
      case (state)
        ARMED: if (pe_fall) begin
          state_n = TIMING;
          count_n = '0;
        end
        TIMING: if (hs_fall) begin
          count_n = count_inc;
          if (count_inc == pulse_len) state_n = DONE;
        end
        default: ;
      endcase
    end
  end

  // Stage p2: FSM, pulse output and per-frame position latch
  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      count   <= '0;
      PAD_OUT <= 1'b0;
      PAD_SEL <= 1'b0;
      POS_CUR <= ATTRACT_V;
    end else begin
      state   <= state_n;
      count   <= count_n;
      PAD_OUT <= (state_n == TIMING);
      if (frame_latch) begin
        PAD_SEL <= player2_p1;
        POS_CUR <= slew_step(POS_CUR, target);
      end
    end
  end

endmodule

// File: tb/tb_paddle_timer_ctrl.sv
// Directed bench for paddle_timer_ctrl: frame latch, slew limiting, pulse
// length in scanlines, truncation, dropped triggers and asynchronous reset.
module tb_paddle_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync_n, hsync_n, pad_en_n, player2, attract_n;
  logic [7:0] pos1, pos2;
  logic       pad_out, pad_sel;
  logic [7:0] pos_cur;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  paddle_timer_ctrl dut (
    .CLK_DRV   (clk),
    .RESET     (rst),
    .VSYNC_N   (vsync_n),
    .HSYNC_N   (hsync_n),
    .PAD_EN_N  (pad_en_n),
    .POS1      (pos1),
    .POS2      (pos2),
    .PLAYER2   (player2),
    .ATTRACT_N (attract_n),
    .PAD_OUT   (pad_out),
    .PAD_SEL   (pad_sel),
    .POS_CUR   (pos_cur)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic line();
    hsync_n = 1'b0; cyc(4);
    hsync_n = 1'b1; cyc(4);
  endtask

  task automatic vsync();
    cyc(4);
    vsync_n = 1'b0; cyc(4);
    vsync_n = 1'b1; cyc(4);
  endtask

  task automatic trigger();
    pad_en_n = 1'b0; cyc(4);
    pad_en_n = 1'b1; cyc(2);
  endtask

  // Fires the one-shot and counts HSYNC falls until PAD_OUT drops (bounded)
  task automatic measure_pulse(input int exp, input string name);
    int n = 0;
    trigger();
    checks++;
    if (pad_out !== 1'b1) begin
      failures++;
      $display("FAIL %s_start pad_out=%b want 1", name, pad_out);
    end
    while (pad_out === 1'b1 && n < 300) begin
      line();
      n++;
    end
    checks++;
    if (n != exp) begin
      failures++;
      $display("FAIL %s_len lines=%0d want %0d", name, n, exp);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (pad_out !== 1'b0 || pad_sel !== 1'b0 || pos_cur !== 8'd128) begin
      failures++;
      $display("FAIL reset_state pad_out=%b sel=%b pos=%0d want 0 0 128", pad_out, pad_sel, pos_cur);
    end
    trigger();
    line(); line();
    checks++;
    if (pad_out !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_pulse pad_out=%b want 0", pad_out);
    end
  endtask

  task automatic test_attract();
    attract_n = 1'b0; pos1 = 8'd10;
    for (int f = 0; f < 3; f++) begin
      vsync();
      checks++;
      if (pos_cur !== 8'd128 || pad_sel !== 1'b0) begin
        failures++;
        $display("FAIL attract_frame%0d pos=%0d sel=%b want 128 0", f, pos_cur, pad_sel);
      end
      measure_pulse(72, "attract_pulse");
    end
  endtask

  task automatic test_slew();
    int exp_pos [5] = '{144, 160, 176, 192, 200};
    int exp_len [5] = '{80, 88, 96, 104, 108};
    attract_n = 1'b1; player2 = 1'b0; pos1 = 8'd200;
    for (int f = 0; f < 5; f++) begin
      vsync();
      checks++;
      if (pos_cur !== exp_pos[f][7:0]) begin
        failures++;
        $display("FAIL slew_pos%0d pos=%0d want %0d", f, pos_cur, exp_pos[f]);
      end
      measure_pulse(exp_len[f], "slew_pulse");
    end
  endtask

  task automatic test_player_switch();
    pos2 = 8'd40; player2 = 1'b1;
    cyc(8);
    checks++;
    if (pad_sel !== 1'b0 || pos_cur !== 8'd200) begin
      failures++;
      $display("FAIL switch_hold sel=%b pos=%0d want 0 200", pad_sel, pos_cur);
    end
    vsync();
    checks++;
    if (pad_sel !== 1'b1 || pos_cur !== 8'd184) begin
      failures++;
      $display("FAIL switch_latch sel=%b pos=%0d want 1 184", pad_sel, pos_cur);
    end
    measure_pulse(100, "switch_pulse");
  endtask

  task automatic test_extremes();
    int up [5] = '{200, 216, 232, 248, 255};
    int exp;
    player2 = 1'b0; pos1 = 8'd255;
    for (int f = 0; f < 5; f++) begin
      vsync();
      checks++;
      if (pos_cur !== up[f][7:0]) begin
        failures++;
        $display("FAIL up_pos%0d pos=%0d want %0d", f, pos_cur, up[f]);
      end
    end
    measure_pulse(135, "max_pulse");
    pos1 = 8'd0;
    for (int f = 1; f <= 16; f++) begin
      vsync();
      exp = (f == 16) ? 0 : 255 - 16 * f;
      checks++;
      if (pos_cur !== exp[7:0]) begin
        failures++;
        $display("FAIL down_pos%0d pos=%0d want %0d", f, pos_cur, exp);
      end
    end
    measure_pulse(8, "min_pulse");
  endtask

  task automatic test_truncate();
    attract_n = 1'b0;
    for (int f = 1; f <= 8; f++) vsync();
    checks++;
    if (pos_cur !== 8'd128) begin
      failures++;
      $display("FAIL trunc_settle pos=%0d want 128", pos_cur);
    end
    vsync();
    trigger();
    for (int i = 0; i < 10; i++) line();
    checks++;
    if (pad_out !== 1'b1) begin
      failures++;
      $display("FAIL trunc_mid pad_out=%b want 1", pad_out);
    end
    vsync();
    checks++;
    if (pad_out !== 1'b0) begin
      failures++;
      $display("FAIL trunc_drop pad_out=%b want 0", pad_out);
    end
    measure_pulse(72, "after_trunc");
    trigger();
    line(); line(); line();
    checks++;
    if (pad_out !== 1'b0) begin
      failures++;
      $display("FAIL done_retrigger pad_out=%b want 0", pad_out);
    end
  endtask

  task automatic test_back_to_back();
    cyc(4);
    vsync_n = 1'b0; pad_en_n = 1'b0; cyc(4);
    vsync_n = 1'b1; pad_en_n = 1'b1; cyc(4);
    line(); line();
    checks++;
    if (pad_out !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_drop pad_out=%b want 0", pad_out);
    end
    measure_pulse(72, "after_same_cycle");
  endtask

  task automatic test_reset_mid();
    attract_n = 1'b1; player2 = 1'b1; pos2 = 8'd0;
    vsync();
    checks++;
    if (pos_cur !== 8'd112 || pad_sel !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset pos=%0d sel=%b want 112 1", pos_cur, pad_sel);
    end
    trigger();
    for (int i = 0; i < 5; i++) line();
    rst = 1'b1;
    #1;
    checks++;
    if (pad_out !== 1'b0 || pos_cur !== 8'd128 || pad_sel !== 1'b0) begin
      failures++;
      $display("FAIL async_reset pad_out=%b pos=%0d sel=%b want 0 128 0", pad_out, pos_cur, pad_sel);
    end
    cyc(3);
    rst = 1'b0;
    cyc(4);
    trigger();
    line();
    checks++;
    if (pad_out !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle pad_out=%b want 0", pad_out);
    end
  endtask

  initial begin
    rst = 1'b1; vsync_n = 1'b1; hsync_n = 1'b1; pad_en_n = 1'b1;
    player2 = 1'b0; attract_n = 1'b0; pos1 = 8'd0; pos2 = 8'd0;
    cyc(3);
    rst = 1'b0;
    cyc(4);
    test_reset();
    test_attract();
    test_slew();
    test_player_switch();
    test_extremes();
    test_truncate();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
